onehot_pulse_decoder: RTL

//   Registered N:2^N decoder, the inverse of the 8:3 priority encoder. Accepts a

---
 rtl/onehot_pulse_decoder.sv | 120 ++++++++++++
 1 files changed

// File: rtl/onehot_pulse_decoder.sv
// Purpose : registered N:2^N decoder; drives 1<<code for HOLD_CYCLES clocks, then idles GAP_CYCLES clocks.
// Latency : one-hot word visible 1 clock after the in_valid/in_ready handshake, held HOLD_CYCLES clocks.
// Backpr. : in_ready is low through HOLD and GAP; code/in_valid changes are ignored until IDLE.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   in_valid     code is valid          in_ready    decoder in IDLE, can accept
//   code [N-1:0] binary index           onehot_out  decoded word, zero outside HOLD
//   out_valid    high exactly in HOLD   busy        high in HOLD or GAP
// Optional build macro PARITY_CHK_EN:
//   code_par     even parity over code  err_pulse   1-clock pulse when an accepted code fails parity
//
// With in_valid held high, HOLD and GAP are followed by one IDLE clock in which
// the next code is taken, so back-to-back accepts are HOLD_CYCLES+GAP_CYCLES+1
// edges apart.
module onehot_pulse_decoder #(
    parameter int N           = 3,
    parameter int HOLD_CYCLES = 4,
    parameter int GAP_CYCLES  = 1,
    localparam int W          = 1 << N
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] code,
`ifdef PARITY_CHK_EN
    input  logic         code_par,
    output logic         err_pulse,
`endif
    output logic [W-1:0] onehot_out,
    output logic         out_valid,
    output logic         busy
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] HOLD = 2'd1;
    localparam logic [1:0] GAP  = 2'd2;

    localparam int MAXC = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    localparam logic [CW-1:0] HOLD_LD = CW'(HOLD_CYCLES - 1);
    // GAP_LD is never loaded when GAP_CYCLES is 0; keep it a clean zero then.
    localparam logic [CW-1:0] GAP_LD  = (GAP_CYCLES > 0) ? CW'(GAP_CYCLES - 1) : '0;
    localparam logic [W-1:0]  ONE     = {{(W-1){1'b0}}, 1'b1};

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic          code_ok;

`ifdef PARITY_CHK_EN
    // Even parity: code bits plus code_par must XOR to zero.
    assign code_ok = ~(^{code, code_par});
`else
    assign code_ok = 1'b1;
`endif

    assign in_ready = (state == IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            onehot_out <= '0;
            out_valid  <= 1'b0;
            busy       <= 1'b0;
`ifdef PARITY_CHK_EN
            err_pulse  <= 1'b0;
`endif
        end else begin
`ifdef PARITY_CHK_EN
            // A bad-parity code is consumed in IDLE and only flagged.
            err_pulse <= in_valid && (state == IDLE) && !code_ok;
`endif
            case (state)
                IDLE: begin
                    if (in_valid && code_ok) begin
                        state      <= HOLD;
                        cnt        <= HOLD_LD;
                        onehot_out <= ONE << code;
                        out_valid  <= 1'b1;
                        busy       <= 1'b1;
                    end
                end
                HOLD: begin
                    if (cnt == '0) begin
                        onehot_out <= '0;
                        out_valid  <= 1'b0;
                        if (GAP_CYCLES > 0) begin
                            state <= GAP;
                            cnt   <= GAP_LD;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                GAP: begin
                    if (cnt == '0) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: begin
                    state      <= IDLE;
                    cnt        <= '0;
                    onehot_out <= '0;
                    out_valid  <= 1'b0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule
